// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states, parity encodings and the
// oversampling ratio common to the tx and (future) rx controllers.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: paces a start/data/parity/stop frame onto tx
// using the 16x oversampling tick from the baud-rate generator.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16,
    parameter int unsigned PARITY  = PAR_NONE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx_ready,
    output logic            tx_done_tick,
    output logic            tx
);

    // Tick counter must reach SB_TICK-1 for long stop bits.
    localparam int unsigned SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
    localparam int unsigned NW = $clog2(DBIT);

    localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    tx_state_t       state;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] b;
    logic            par;
    logic            tx_reg;

    logic par_next;
    logic par_bit;

    assign par_next = par ^ b[0];
    assign par_bit  = (PARITY == PAR_ODD) ? ~par_next : par_next;

    assign tx_ready = (state == IDLE);
    assign tx       = tx_reg;

    // tx_reg is loaded with the next bit's level on each transition so the
    // line is registered yet changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            par          <= 1'b0;
            tx_reg       <= 1'b1;
            tx_done_tick <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            unique case (state)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (tx_start) begin
                        b      <= din;
                        s      <= '0;
                        par    <= 1'b0;
                        tx_reg <= 1'b0;
                        state  <= START;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == S_BIT_LAST) begin
                            s      <= '0;
                            n      <= '0;
                            tx_reg <= b[0];
                            state  <= DATA;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == S_BIT_LAST) begin
                            s   <= '0;
                            par <= par_next;
                            b   <= b >> 1;
                            if (n == N_LAST) begin
                                if (PARITY != PAR_NONE) begin
                                    tx_reg <= par_bit;
                                    state  <= PAR;
                                end else begin
                                    tx_reg <= 1'b1;
                                    state  <= STOP;
                                end
                            end else begin
                                n      <= n + NW'(1);
                                tx_reg <= b[1];
                            end
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                PAR: begin
                    if (s_tick) begin
                        if (s == S_BIT_LAST) begin
                            s      <= '0;
                            tx_reg <= 1'b1;
                            state  <= STOP;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s == S_STOP_LAST) begin
                            s            <= '0;
                            tx_done_tick <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: four configurations share clock, tick,
// reset and din; each frame's expected line image is queued at issue time.
module tb_uart_tx_ctrl;

    typedef struct {
        int          dut;
        logic [11:0] bits;
        int          nbits;
        int          bit_clk;
        int          total;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_tick;
    logic [3:0] tx_start;
    logic [7:0] din;
    logic [3:0] tx_v;
    logic [3:0] ready_v;
    logic [3:0] done_v;

    frame_t exp_q[$];
    bit [3:0] abort_ok;
    int n_tests = 0;
    int n_fail  = 0;
    int tick_div = 1;
    int phase = 0;

    always #5 clk = ~clk;

    // 0: no parity, 1: even, 2: odd, 3: no parity with 2 stop bits
    uart_tx_ctrl #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_p0 (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start[0]), .din(din),
        .tx_ready(ready_v[0]), .tx_done_tick(done_v[0]), .tx(tx_v[0]));
    uart_tx_ctrl #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_even (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start[1]), .din(din),
        .tx_ready(ready_v[1]), .tx_done_tick(done_v[1]), .tx(tx_v[1]));
    uart_tx_ctrl #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u_odd (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start[2]), .din(din),
        .tx_ready(ready_v[2]), .tx_done_tick(done_v[2]), .tx(tx_v[2]));
    uart_tx_ctrl #(.DBIT(8), .SB_TICK(32), .PARITY(0)) u_sb2 (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start[3]), .din(din),
        .tx_ready(ready_v[3]), .tx_done_tick(done_v[3]), .tx(tx_v[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // One clock step: inputs change at the falling edge, tx_start is a pulse.
    task automatic cyc();
        @(negedge clk);
        if (tx_start != '0) din = 8'($urandom);
        tx_start = '0;
        s_tick = (phase == 0);
        phase = (phase + 1 >= tick_div) ? 0 : phase + 1;
    endtask

    task automatic send(input int k, input logic [7:0] d, input bit push,
                        input logic [11:0] bits, input int nbits, input int bit_clk, input int total);
        int guard = 0;
        do begin
            cyc();
            guard++;
        end while (!(s_tick && ready_v[k]) && guard < 5000);
        if (guard >= 5000) check($sformatf("dut%0d_send_timeout", k), ready_v[k], 1);
        tx_start[k] = 1'b1;
        din = d;
        if (push) exp_q.push_back('{k, bits, nbits, bit_clk, total});
    endtask

    task automatic wait_done(input int k);
        int guard = 0;
        do begin
            cyc();
            guard++;
        end while (done_v[k] !== 1'b1 && guard < 5000);
        if (guard >= 5000) check($sformatf("dut%0d_done_timeout", k), done_v[k], 1);
    endtask

    // Captures tx from the first busy cycle until tx_ready returns, then
    // checks length and every bit cell against the queued frame.
    task automatic monitor(input int k);
        bit     cap = 0;
        logic   smp[$];
        frame_t e;
        forever begin
            @(negedge clk);
            if (cap && ready_v[k] === 1'b1) begin
                cap = 0;
                if (done_v[k] === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("dut%0d_unexpected_frame", k), done_v[k], 0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("dut%0d_owner", k), k, e.dut);
                        check($sformatf("dut%0d_frame_len", k), smp.size(), e.total);
                        for (int i = 0; i < e.nbits; i++) begin
                            int lo  = i * e.bit_clk;
                            int hi  = (i == e.nbits - 1) ? e.total : lo + e.bit_clk;
                            int bad = 0;
                            for (int j = lo; j < hi; j++)
                                if (j >= smp.size() || smp[j] !== e.bits[i]) bad++;
                            check($sformatf("dut%0d_bit%0d_wrong_samples_lvl%0d", k, i, e.bits[i]), bad, 0);
                        end
                    end
                end else if (abort_ok[k]) begin
                    abort_ok[k] = 1'b0;
                end else begin
                    check($sformatf("dut%0d_early_ready", k), done_v[k], 1);
                end
            end else if (!cap && done_v[k] === 1'b1) begin
                check($sformatf("dut%0d_stray_done", k), done_v[k], 0);
            end
            if (!cap && ready_v[k] === 1'b0) begin
                cap = 1;
                smp.delete();
            end
            if (cap) smp.push_back(tx_v[k]);
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);
    initial monitor(3);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s_tick = 1'b0;
        tx_start = '0;
        din = '0;
        abort_ok = '0;
        repeat (3) cyc();
        check("reset_tx", tx_v, 4'hF);
        check("reset_ready", ready_v, 4'hF);
        check("reset_done", done_v, 4'h0);
        rst = 1'b0;

        // Basic frame, ignored mid-frame start, then back-to-back start.
        tick_div = 1;
        send(0, 8'hA5, 1, 12'b1101001010, 10, 16, 160);
        repeat (80) cyc();
        check("busy_ready", ready_v[0], 0);
        tx_start[0] = 1'b1;
        din = 8'h3C;
        wait_done(0);
        tx_start[0] = 1'b1;
        din = 8'h3C;
        exp_q.push_back('{0, 12'b1001111000, 10, 16, 160});
        cyc();
        check("b2b_tx_low", tx_v[0], 0);
        check("b2b_busy", ready_v[0], 0);
        check("done_one_cycle", done_v[0], 0);
        wait_done(0);
        cyc();

        // Even and odd parity on 8'hA5 (four ones).
        send(1, 8'hA5, 1, 12'b10101001010, 11, 16, 176);
        wait_done(1);
        cyc();
        send(2, 8'hA5, 1, 12'b11101001010, 11, 16, 176);
        wait_done(2);
        cyc();

        // Two stop bits.
        send(3, 8'hA5, 1, 12'b1101001010, 10, 16, 176);
        wait_done(3);
        cyc();

        // Tick every 5 clk; start coincides with a tick that must not count.
        tick_div = 5;
        phase = 0;
        send(0, 8'hA5, 1, 12'b1101001010, 10, 80, 800);
        wait_done(0);
        cyc();

        // Reset during data bit 3, then a clean frame.
        tick_div = 1;
        phase = 0;
        send(0, 8'hA5, 0, 12'b0, 10, 16, 160);
        repeat (70) cyc();
        abort_ok[0] = 1'b1;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst_tx", tx_v[0], 1);
        check("midrst_ready", ready_v[0], 1);
        check("midrst_done", done_v[0], 0);
        repeat (200) cyc();
        send(0, 8'h0F, 1, 12'b1000011110, 10, 16, 160);
        wait_done(0);

        repeat (5) cyc();
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
